half_sub: RTL and testbench
===========================

HALF_SUB -- requirements
Module: half_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent bit lanes in a, b, diff and borrow.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of borrow_cnt.
REQ-003 Reset is asynchronous and active-low; the clock port SHALL be named clk and the reset port rst_n.
REQ-004 Port clk SHALL be an input, 1 bit: the rising-edge clock for all state.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port a SHALL be an input, WIDTH bits: the minuend.
REQ-007 Port b SHALL be an input, WIDTH bits: the subtrahend.
REQ-008 Port in_valid SHALL be an input, 1 bit: marks a and b as valid this cycle.
REQ-009 Port clr_cnt SHALL be an input, 1 bit: synchronous clear of borrow_cnt.
REQ-010 Port diff SHALL be an output, WIDTH bits: registered per-lane difference.
REQ-011 Port borrow SHALL be an output, WIDTH bits: registered per-lane borrow-out.
REQ-012 Port out_valid SHALL be an output, 1 bit: diff and borrow hold a new result this cycle.
REQ-013 Port borrow_cnt SHALL be an output, CNT_W bits: saturating count of accepted operations with any borrow bit set.

Function
REQ-014 For each lane i, the block SHALL compute diff[i] = a[i] XOR b[i] and borrow[i] = (NOT a[i]) AND b[i].
REQ-015 On each rising clk edge with in_valid=1, diff and borrow SHALL load the results from REQ-014, giving 1-cycle latency.
REQ-016 On each rising clk edge with in_valid=0, diff and borrow SHALL hold their previous values.
REQ-017 out_valid SHALL be in_valid delayed by one clock cycle.
REQ-018 On an accepted operation (in_valid=1) where the reduction OR of the computed borrow bits is 1, borrow_cnt SHALL increment by 1.
REQ-019 When borrow_cnt is all-ones, it SHALL NOT increment further; it saturates and does not wrap.
REQ-020 When clr_cnt=1, borrow_cnt SHALL become 0 on the next edge; clr_cnt has priority over a simultaneous increment.
REQ-021 Back-to-back valid inputs SHALL be accepted every cycle, with no stall and no backpressure.
REQ-022 Unknown values on a or b while in_valid=0 SHALL NOT change any register.

Reset
REQ-023 While rst_n=0, diff, borrow, out_valid and borrow_cnt SHALL be 0 immediately, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight result; out_valid SHALL be 0 on the first edge after release unless in_valid=1 at that edge.
REQ-025 After rst_n deasserts, the first rising clk edge SHALL perform normal operation.

Configuration
REQ-026 Macro HALF_SUB_BORROW_CNT_EN SHALL control the borrow counter.
REQ-027 With HALF_SUB_BORROW_CNT_EN defined, the counter SHALL behave per REQ-018 to REQ-020.
REQ-028 Without HALF_SUB_BORROW_CNT_EN, no counter logic SHALL be built; borrow_cnt SHALL be tied to 0 and clr_cnt ignored.
REQ-029 The port list and all other behaviour SHALL be identical whether or not HALF_SUB_BORROW_CNT_EN is defined.

Verification
REQ-030 Truth table: with WIDTH=1, apply in_valid=1 and (a,b)=00, 01, 10, 11 on successive cycles. Required (diff,borrow) one cycle later: 00, 11, 10, 00, with out_valid=1 on each.
REQ-031 Hold test: present a=0, b=1, valid, then set in_valid=0 and toggle a and b. diff=1 and borrow=1 SHALL persist, and out_valid SHALL drop to 0.
REQ-032 Counter test, with HALF_SUB_BORROW_CNT_EN defined: apply the 4-vector sequence of REQ-030 three times; borrow_cnt SHALL equal 3. Then assert clr_cnt together with a=0, b=1 valid; borrow_cnt SHALL equal 0.
REQ-033 Saturation test: with CNT_W=2, apply 5 borrow-generating vectors; borrow_cnt SHALL equal 3.
REQ-034 Async reset test: drive rst_n low between clock edges after results are loaded. All outputs SHALL read 0 before the next edge.
REQ-035 Multi-lane test: with WIDTH=4, a=4'b0101 and b=4'b0011 valid. One cycle later diff SHALL be 4'b0110 and borrow 4'b0010.

Source files
------------

// File: rtl/half_sub.sv
// half_sub: registered multi-lane half subtractor.
//
// Each of WIDTH independent lanes computes diff = a ^ b and
// borrow = ~a & b. The results are registered with one cycle of latency.
//
// Optional borrow counter: define HALF_SUB_BORROW_CNT_EN to build a
// saturating count of accepted operations that produced any borrow bit.
// When the macro is undefined, borrow_cnt is tied to zero and clr_cnt is
// ignored. The port list is the same in both builds.
//
// Handshake: in_valid qualifies a and b in the cycle it is high. There is
// no ready signal. Every valid cycle is accepted, including back-to-back
// cycles. out_valid is in_valid delayed by one cycle and marks diff/borrow
// as freshly loaded. While in_valid is low, diff and borrow hold their
// values, and the state of a/b (including X) cannot reach any register.
module half_sub #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  logic [WIDTH-1:0] diff_calc;
  logic [WIDTH-1:0] borrow_calc;

  logic [WIDTH-1:0] diff_d,      diff_q;
  logic [WIDTH-1:0] borrow_d,    borrow_q;
  logic             out_valid_d, out_valid_q;

  // Per-lane half-subtractor equations, computed every cycle.
  always_comb begin
    diff_calc   = a ^ b;
    borrow_calc = ~a & b;
  end

  // Load on valid, otherwise hold. The mux keeps X on idle inputs out of the flops.
  always_comb begin
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      diff_d   = diff_calc;
      borrow_d = borrow_calc;
    end
  end

  // Result registers; the asynchronous reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q      <= '0;
      borrow_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign out_valid = out_valid_q;

`ifdef HALF_SUB_BORROW_CNT_EN

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear wins over increment. The counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (in_valid && (|borrow_calc) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;

`else

  // No counter is built. clr_cnt is deliberately left with no effect.
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign borrow_cnt     = '0;

`endif

endmodule

// File: tb/tb_half_sub.sv
// tb_half_sub: directed bench for half_sub.
// u_dut  : WIDTH=1, CNT_W=16 (truth table, hold, counter/clear, async reset)
// u_dut4 : WIDTH=4, CNT_W=2  (multi-lane, counter saturation)
module tb_half_sub;

`ifdef HALF_SUB_BORROW_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-lane instance
  logic        a, b, in_valid, clr_cnt;
  logic        diff, borrow, out_valid;
  logic [15:0] borrow_cnt;

  // four-lane instance
  logic [3:0]  a4, b4;
  logic        in_valid4, clr_cnt4;
  logic [3:0]  diff4, borrow4;
  logic        out_valid4;
  logic [1:0]  borrow_cnt4;

  half_sub #(.WIDTH(1), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .clr_cnt    (clr_cnt),
    .diff       (diff),
    .borrow     (borrow),
    .out_valid  (out_valid),
    .borrow_cnt (borrow_cnt)
  );

  half_sub #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a4),
    .b          (b4),
    .in_valid   (in_valid4),
    .clr_cnt    (clr_cnt4),
    .diff       (diff4),
    .borrow     (borrow4),
    .out_valid  (out_valid4),
    .borrow_cnt (borrow_cnt4)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive1(input logic va, input logic vb, input logic vv, input logic vc);
    a = va; b = vb; in_valid = vv; clr_cnt = vc;
  endtask

  task automatic drive4(input logic [3:0] va, input logic [3:0] vb, input logic vv);
    a4 = va; b4 = vb; in_valid4 = vv; clr_cnt4 = 1'b0;
  endtask

  // one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_a [4];
  logic [1:0] tt_exp [4];
  logic [1:0] exp_db;
  logic [1:0] exp_cnt4 [5];

  initial begin
    // a,b pairs and hand-computed {diff,borrow}
    tt_a[0] = 2'b00; tt_exp[0] = 2'b00;
    tt_a[1] = 2'b01; tt_exp[1] = 2'b11;
    tt_a[2] = 2'b10; tt_exp[2] = 2'b10;
    tt_a[3] = 2'b11; tt_exp[3] = 2'b00;

    // reset state
    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive4(4'h0, 4'h0, 1'b0);
    #3;
    check("rst_diff",      {31'd0, diff},       32'd0);
    check("rst_borrow",    {31'd0, borrow},     32'd0);
    check("rst_out_valid", {31'd0, out_valid},  32'd0);
    check("rst_cnt",       {16'd0, borrow_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;

    // truth table, three back-to-back passes
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive1(tt_a[i][1], tt_a[i][0], 1'b1, 1'b0);
        exp_q.push_back(tt_exp[i]);
        tick();
        exp_db = exp_q.pop_front();
        check($sformatf("tt_diff_p%0d_v%0d", p, i),   {31'd0, diff},      {31'd0, exp_db[1]});
        check($sformatf("tt_borrow_p%0d_v%0d", p, i), {31'd0, borrow},    {31'd0, exp_db[0]});
        check($sformatf("tt_valid_p%0d_v%0d", p, i),  {31'd0, out_valid}, 32'd1);
      end
    end
    check("cnt_after_3_passes", {16'd0, borrow_cnt}, CNT_EN ? 32'd3 : 32'd0);

    // clear with a simultaneous borrow-generating vector
    drive1(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    check("clr_cnt",    {16'd0, borrow_cnt}, 32'd0);
    check("clr_diff",   {31'd0, diff},       32'd1);
    check("clr_borrow", {31'd0, borrow},     32'd1);

    // hold: idle inputs toggle, including X
    drive1(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("hold1_diff",   {31'd0, diff},      32'd1);
    check("hold1_borrow", {31'd0, borrow},    32'd1);
    check("hold1_valid",  {31'd0, out_valid}, 32'd0);
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("hold2_diff",   {31'd0, diff},   32'd1);
    check("hold2_borrow", {31'd0, borrow}, 32'd1);
    drive1(1'bx, 1'bx, 1'b0, 1'b0);
    tick();
    check("holdx_diff",   {31'd0, diff},       32'd1);
    check("holdx_borrow", {31'd0, borrow},     32'd1);
    check("holdx_cnt",    {16'd0, borrow_cnt}, 32'd0);

    // multi-lane, then saturation on the 2-bit counter
    exp_cnt4[0] = 2'd1; exp_cnt4[1] = 2'd2; exp_cnt4[2] = 2'd3;
    exp_cnt4[3] = 2'd3; exp_cnt4[4] = 2'd3;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive4(4'b0101, 4'b0011, 1'b1);
    tick();
    check("ml_diff",   {28'd0, diff4},      32'h6);
    check("ml_borrow", {28'd0, borrow4},    32'h2);
    check("ml_valid",  {31'd0, out_valid4}, 32'd1);
    check("sat_cnt0",  {30'd0, borrow_cnt4}, CNT_EN ? {30'd0, exp_cnt4[0]} : 32'd0);
    for (int i = 1; i < 5; i++) begin
      drive4(4'h0, 4'hf, 1'b1);
      tick();
      check($sformatf("sat_cnt%0d", i), {30'd0, borrow_cnt4}, CNT_EN ? {30'd0, exp_cnt4[i]} : 32'd0);
    end
    check("sat_borrow", {28'd0, borrow4}, 32'hf);
    check("sat_diff",   {28'd0, diff4},   32'hf);

    // async reset between edges with results loaded
    drive4(4'h0, 4'h0, 1'b0);
    drive1(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_diff",     {31'd0, diff},        32'd0);
    check("arst_borrow",   {31'd0, borrow},      32'd0);
    check("arst_valid",    {31'd0, out_valid},   32'd0);
    check("arst_cnt",      {16'd0, borrow_cnt},  32'd0);
    check("arst_diff4",    {28'd0, diff4},       32'd0);
    check("arst_borrow4",  {28'd0, borrow4},     32'd0);
    check("arst_cnt4",     {30'd0, borrow_cnt4}, 32'd0);

    // release with in_valid low: nothing in flight appears
    tick();
    drive1(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rel_valid", {31'd0, out_valid}, 32'd0);
    check("rel_diff",  {31'd0, diff},      32'd0);

    // normal operation right after reset
    drive1(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("post_diff",   {31'd0, diff},       32'd1);
    check("post_borrow", {31'd0, borrow},     32'd0);
    check("post_valid",  {31'd0, out_valid},  32'd1);
    check("post_cnt",    {16'd0, borrow_cnt}, 32'd0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
